// File: rtl/bcd_coordinate_converter_pkg.sv
// Shared types and constants for the coordinate/score BCD converter.
package coord_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_NINE = 4'h9;

    // 10**n, wide enough for DIGITS up to 10; used for the overflow limit.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_coordinate_converter_if.sv
// Bus between a binary value source and the BCD converter.
// Handshake: a value is accepted on a rising edge where in_valid and in_ready
// are both high; out_valid is a single-cycle pulse with no back-pressure, and
// bcd_out/overflow/blank_mask stay stable until the next pulse.
interface bcd_coordinate_converter_if #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      binary_in;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
    logic [DIGITS-1:0]     blank_mask;

    modport master (
        output in_valid, binary_in,
        input  in_ready, out_valid, bcd_out, overflow, blank_mask
    );

    modport slave (
        input  in_valid, binary_in,
        output in_ready, out_valid, bcd_out, overflow, blank_mask
    );
endinterface

// File: rtl/bcd_coordinate_converter_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_nibble (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    // Combinational add-3 correction.
    always_comb begin
        nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;
    end
endmodule

// File: rtl/bcd_coordinate_converter.sv
// Iterative binary-to-BCD converter (double dabble, one bit per clock).
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN;
// without it blank_mask is held at zero.
module bcd_coordinate_converter
    import coord_disp_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    bcd_coordinate_converter_if.slave cv_if,
    output state_e dbg_state_o
);
    localparam int          SCR_W     = BCD_W * DIGITS + BCD_W;  // one guard nibble
    localparam int          CNT_W     = $clog2(BIN_W) + 1;
    localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

    state_e                state_q, state_d;
    logic [BIN_W-1:0]      shreg_q, shreg_d, shreg_sh;
    logic [SCR_W-1:0]      scratch_q, scratch_d, scratch_adj, scratch_sh;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_out_q, ovf_out_d;
    logic [DIGITS-1:0]     mask_q, mask_d, mask_calc;
    logic                  in_ready;
    logic                  out_valid;

    // Add-3 correction on every scratch nibble, guard nibble included.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .nib_i (scratch_q[g*BCD_W +: BCD_W]),
            .nib_o (scratch_adj[g*BCD_W +: BCD_W])
        );
    end

    // One double-dabble step: corrected scratch and shift register move left as one vector.
    always_comb begin
        {scratch_sh, shreg_sh} = {scratch_adj, shreg_q} << 1;
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // Blank every digit above the highest nonzero one; digit 0 is always shown.
    always_comb begin
        logic seen_nz;
        seen_nz   = 1'b0;
        mask_calc = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (scratch_sh[i*BCD_W +: BCD_W] != 4'd0) begin
                seen_nz = 1'b1;
            end
            mask_calc[i] = ~seen_nz;
        end
    end
`else
    // Blanking disabled: no digit is ever suppressed.
    always_comb begin
        mask_calc = '0;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;
        mask_d    = mask_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (cv_if.in_valid) begin
                    state_d   = S_SHIFT;
                    shreg_d   = cv_if.binary_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W - 1);
                    ovf_d     = (64'(cv_if.binary_in) >= OVF_LIMIT);
                end
            end
            S_SHIFT: begin
                scratch_d = scratch_sh;
                shreg_d   = shreg_sh;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    // Last shift: publish the result as DONE is entered.
                    state_d   = S_DONE;
                    ovf_out_d = ovf_q;
                    bcd_d     = ovf_q ? {DIGITS{BCD_NINE}} : scratch_sh[4*DIGITS-1:0];
                    mask_d    = ovf_q ? '0 : mask_calc;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and result registers; reset aborts any conversion in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
            mask_q    <= '0;
        end else begin
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
            mask_q    <= mask_d;
        end
    end

    assign cv_if.in_ready   = in_ready;
    assign cv_if.out_valid  = out_valid;
    assign cv_if.bcd_out    = bcd_q;
    assign cv_if.overflow   = ovf_out_q;
    assign cv_if.blank_mask = mask_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_bcd_coordinate_converter.sv
// Bench for bcd_coordinate_converter: one 12-bit/4-digit instance (A) and one
// 12-bit/3-digit instance (B) for the overflow cases. Expected mask values
// follow BCD_LEADING_ZERO_BLANK_EN.
module tb_bcd_coordinate_converter;
    import coord_disp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {overflow, blank_mask, bcd_out}
    logic [20:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];
    int          acc_a_q[$];
    int          acc_cnt  = 0;
    int          last_acc = 0;
    int          prev_acc = 0;

    state_e a_state, b_state;

    bcd_coordinate_converter_if #(.BIN_W(12), .DIGITS(4)) a_if ();
    bcd_coordinate_converter_if #(.BIN_W(12), .DIGITS(3)) b_if ();

    bcd_coordinate_converter #(.BIN_W(12), .DIGITS(4)) dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .cv_if       (a_if.slave),
        .dbg_state_o (a_state)
    );

    bcd_coordinate_converter #(.BIN_W(12), .DIGITS(3)) dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .cv_if       (b_if.slave),
        .dbg_state_o (b_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] em4(input logic [3:0] m);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        return m;
`else
        return 4'b0000;
`endif
    endfunction

    function automatic logic [2:0] em3(input logic [2:0] m);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        return m;
`else
        return 3'b000;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT, expected progress (t=%0t)", name, $time);
    endtask

    // Driver for A: hold in_valid until accepted, then drop it.
    task automatic send_a(input logic [11:0] v, input logic [20:0] exp, input bit push);
        int t;
        t = 0;
        a_if.in_valid  = 1'b1;
        a_if.binary_in = v;
        @(negedge clk);
        while (!a_if.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            timeout_fail("a_send");
        end else if (push) begin
            exp_a_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
    endtask

    // Driver for B.
    task automatic send_b(input logic [11:0] v, input logic [15:0] exp);
        int t;
        t = 0;
        b_if.in_valid  = 1'b1;
        b_if.binary_in = v;
        @(negedge clk);
        while (!b_if.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            timeout_fail("b_send");
        end else begin
            exp_b_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout_fail("drain");
        repeat (2) @(negedge clk);
    endtask

    // Accept detector for A: the edge after this negedge accepts the value.
    always @(negedge clk) begin
        if (!rst && a_if.in_valid && a_if.in_ready) begin
            acc_a_q.push_back(cyc + 1);
            prev_acc = last_acc;
            last_acc = cyc + 1;
            acc_cnt++;
        end
    end

    // Scoreboard monitor for A
    always @(negedge clk) begin
        if (!rst && a_if.out_valid) begin
            if (exp_a_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_out_valid: got out_valid=1 bcd_out=%h, expected no output", a_if.bcd_out);
            end else begin
                logic [20:0] e;
                e = exp_a_q.pop_front();
                check("a_result", {a_if.overflow, a_if.blank_mask, a_if.bcd_out}, e);
                if (acc_a_q.size() != 0) begin
                    check("a_latency", (cyc + 1) - acc_a_q.pop_front(), 13);
                end
            end
        end
    end

    // Scoreboard monitor for B
    always @(negedge clk) begin
        if (!rst && b_if.out_valid) begin
            if (exp_b_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_out_valid: got out_valid=1 bcd_out=%h, expected no output", b_if.bcd_out);
            end else begin
                check("b_result", {b_if.overflow, b_if.blank_mask, b_if.bcd_out}, exp_b_q.pop_front());
            end
        end
    end

    // Stimulus
    initial begin
        int t;
        int n0;
        a_if.in_valid  = 1'b0;
        a_if.binary_in = '0;
        b_if.in_valid  = 1'b0;
        b_if.binary_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("a_reset_state",   a_state, S_IDLE);
        check("a_reset_ready",   a_if.in_ready, 1);
        check("a_reset_valid",   a_if.out_valid, 0);
        check("a_reset_outputs", {a_if.overflow, a_if.blank_mask, a_if.bcd_out}, 0);
        check("b_reset_ready",   b_if.in_ready, 1);
        check("b_reset_outputs", {b_if.overflow, b_if.blank_mask, b_if.bcd_out}, 0);
        @(posedge clk);
        #1;

        // Directed conversions on A
        send_a(12'd0,    {1'b0, em4(4'b1110), 16'h0000}, 1'b1);
        send_a(12'd4095, {1'b0, em4(4'b0000), 16'h4095}, 1'b1);
        send_a(12'd1234, {1'b0, em4(4'b0000), 16'h1234}, 1'b1);
        send_a(12'd42,   {1'b0, em4(4'b1100), 16'h0042}, 1'b1);
        send_a(12'd1000, {1'b0, em4(4'b0000), 16'h1000}, 1'b1);
        send_a(12'd7,    {1'b0, em4(4'b1110), 16'h0007}, 1'b1);

        // Overflow saturation on B (three digits)
        send_b(12'd1000, {1'b1, 3'b000,       12'h999});
        send_b(12'd999,  {1'b0, em3(3'b000),  12'h999});
        send_b(12'd4095, {1'b1, 3'b000,       12'h999});
        send_b(12'd5,    {1'b0, em3(3'b110),  12'h005});
        send_b(12'd0,    {1'b0, em3(3'b110),  12'h000});
        drain();

        // in_valid held high: value changed during SHIFT is not converted
        @(posedge clk);
        #1;
        a_if.in_valid  = 1'b1;
        a_if.binary_in = 12'd100;
        exp_a_q.push_back({1'b0, em4(4'b1000), 16'h0100});
        t = 0;
        @(negedge clk);
        while (!a_if.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        a_if.binary_in = 12'd200;
        n0 = acc_cnt;
        repeat (6) @(posedge clk);
        #1;
        a_if.binary_in = 12'd300;
        exp_a_q.push_back({1'b0, em4(4'b1000), 16'h0300});
        t = 0;
        @(negedge clk);
        while (!a_if.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout_fail("a_hold_accept");
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
        check("a_accept_count", acc_cnt - n0, 1);
        check("a_accept_spacing", last_acc - prev_acc, 14);
        drain();

        // Reset mid-SHIFT aborts the conversion
        @(posedge clk);
        #1;
        send_a(12'd500, '0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("a_abort_in_shift", a_state, S_SHIFT);
        rst = 1'b1;
        exp_a_q.delete();
        acc_a_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("a_abort_state",   a_state, S_IDLE);
        check("a_abort_ready",   a_if.in_ready, 1);
        check("a_abort_outputs", {a_if.overflow, a_if.blank_mask, a_if.bcd_out}, 0);
        repeat (20) @(negedge clk);

        // Reset and in_valid together: nothing is accepted
        @(posedge clk);
        #1;
        rst            = 1'b1;
        a_if.in_valid  = 1'b1;
        a_if.binary_in = 12'd77;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        a_if.in_valid = 1'b0;
        @(negedge clk);
        check("a_reset_wins_state", a_state, S_IDLE);
        repeat (20) @(negedge clk);

        // Normal operation after reset
        @(posedge clk);
        #1;
        send_a(12'd42, {1'b0, em4(4'b1100), 16'h0042}, 1'b1);
        drain();
        repeat (5) @(negedge clk);
        check("a_queue_drained", exp_a_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
